// File: rtl/pc_if.sv
// Request/status bundle between the control/branch unit and the program counter.
interface pc_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            branch_i;
  logic            call_i;
  logic            ret_i;
  logic [XLEN-1:0] branch_target_i;
  logic [XLEN-1:0] pc_o;
  logic            ras_empty_o;
  logic            ras_full_o;
  logic            ras_overflow_o;
  logic            trap_o;

  modport master (
    output stall_i, branch_i, call_i, ret_i, branch_target_i,
    input  pc_o, ras_empty_o, ras_full_o, ras_overflow_o, trap_o
  );

  modport slave (
    input  stall_i, branch_i, call_i, ret_i, branch_target_i,
    output pc_o, ras_empty_o, ras_full_o, ras_overflow_o, trap_o
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential/stall/branch/call/return and a circular
// return-address stack; misaligned redirects and RAS underflow trap.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);
  localparam int SW = $clog2(STEP);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PW-1:0]   ras_wa;
  logic [XLEN-1:0] ras_wd;
  logic [XLEN-1:0] tgt;
  logic            redirect;
  logic            empty, full;

  function automatic logic misaligned(input logic [XLEN-1:0] a);
    return |a[SW-1:0];
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(RAS_DEPTH));
  assign ras_wd = pc_q + XLEN'(STEP);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    top_d    = top_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    trap_d   = 1'b0;
    ras_we   = 1'b0;
    ras_wa   = top_q;
    tgt      = '0;
    redirect = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.stall_i) begin
          if (bus.ret_i && !bus.call_i && empty) begin
            pc_d   = TRAP_VECTOR;
            trap_d = 1'b1;
          end else if (bus.ret_i && bus.call_i) begin
            // Swap replaces the top in place; on an empty stack it degrades to a push.
            ras_we   = 1'b1;
            tgt      = bus.branch_target_i;
            redirect = 1'b1;
            if (empty) begin
              ras_wa = top_q + 1'b1;
              top_d  = top_q + 1'b1;
              cnt_d  = cnt_q + 1'b1;
            end
          end else if (bus.ret_i) begin
            tgt      = ras_q[top_q];
            redirect = 1'b1;
            top_d    = top_q - 1'b1;
            cnt_d    = cnt_q - 1'b1;
          end else if (bus.call_i) begin
            // When full, top+1 is the oldest slot, so the push overwrites it.
            ras_we   = 1'b1;
            ras_wa   = top_q + 1'b1;
            top_d    = top_q + 1'b1;
            tgt      = bus.branch_target_i;
            redirect = 1'b1;
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + 1'b1;
          end else if (bus.branch_i) begin
            tgt      = bus.branch_target_i;
            redirect = 1'b1;
          end else begin
            pc_d = pc_q + XLEN'(STEP);
          end
          if (redirect) begin
            if (misaligned(tgt)) begin
              pc_d   = TRAP_VECTOR;
              trap_d = 1'b1;
            end else begin
              pc_d = tgt;
            end
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      trap_q  <= trap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_wa] <= ras_wd;
  end

  assign bus.pc_o           = pc_q;
  assign bus.ras_empty_o    = empty;
  assign bus.ras_full_o     = full;
  assign bus.ras_overflow_o = ovf_q;
  assign bus.trap_o         = trap_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_if #(.XLEN(32)) ifa ();
  pc_if #(.XLEN(8))  ifb ();

  pc_unit #(.XLEN(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pc_unit #(.XLEN(8), .TRAP_VECTOR(8'h80)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic [31:0] pc_m;
  logic [31:0] ras_m [$];
  bit          ovf_m, trap_m, boot_m;

  task automatic model_reset();
    pc_m = 32'h0; ras_m.delete(); ovf_m = 0; trap_m = 0; boot_m = 1;
  endtask

  function automatic logic [31:0] goto(input logic [31:0] t);
    if (t[1:0] != 2'b00) begin trap_m = 1; return 32'h100; end
    return t;
  endfunction

  task automatic model_step(input bit st, br, ca, re, input logic [31:0] tg);
    logic [31:0] a;
    trap_m = 0;
    if (boot_m) begin boot_m = 0; return; end
    if (st) return;
    if (re && !ca && ras_m.size() == 0) begin
      pc_m = 32'h100; trap_m = 1;
    end else if (re && ca) begin
      if (ras_m.size() > 0) a = ras_m.pop_back();
      ras_m.push_back(pc_m + 32'd4);
      pc_m = goto(tg);
    end else if (re) begin
      a = ras_m.pop_back();
      pc_m = goto(a);
    end else if (ca) begin
      if (ras_m.size() == 4) begin a = ras_m.pop_front(); ovf_m = 1; end
      ras_m.push_back(pc_m + 32'd4);
      pc_m = goto(tg);
    end else if (br) begin
      pc_m = goto(tg);
    end else begin
      pc_m = pc_m + 32'd4;
    end
  endtask

  task automatic drive(input bit st, br, ca, re, input logic [31:0] tg);
    ifa.stall_i = st; ifa.branch_i = br; ifa.call_i = ca; ifa.ret_i = re;
    ifa.branch_target_i = tg;
    model_step(st, br, ca, re, tg);
    @(posedge clk); #1;
  endtask

  task automatic driveb(input bit br, ca, re, input logic [7:0] tg);
    ifb.stall_i = 0; ifb.branch_i = br; ifb.call_i = ca; ifb.ret_i = re;
    ifb.branch_target_i = tg;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0; model_reset();
    #2; @(negedge clk); rst = 1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    rst = 0; model_reset(); #2;
    total++; if (ifa.pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", ifa.pc_o); end
    total++; if (ifa.ras_empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", ifa.ras_empty_o); end
    total++; if (ifa.ras_full_o !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", ifa.ras_full_o); end
    total++; if (ifa.ras_overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ifa.ras_overflow_o); end
    total++; if (ifa.trap_o !== 1'b0) begin bad++; $display("FAIL rst_trap got=%b exp=0", ifa.trap_o); end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 32'h0);
      total++; if (ifa.pc_o !== exp_seq[i]) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, ifa.pc_o, exp_seq[i]); end
    end
    drive(0, 0, 0, 0, 32'h0);
    total++; if (ifa.pc_o !== 32'h10) begin bad++; $display("FAIL seq_pc[4] got=%h exp=10", ifa.pc_o); end
    #2; rst = 0; #1;
    total++; if (ifa.pc_o !== 32'h0) begin bad++; $display("FAIL async_rst_pc got=%h exp=0", ifa.pc_o); end
    total++; if (ifa.trap_o !== 1'b0) begin bad++; $display("FAIL async_rst_trap got=%b exp=0", ifa.trap_o); end
    model_reset();
    @(negedge clk); rst = 1;
  endtask

  task automatic test_stall_branch();
    do_reset();
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h40);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 32'h999);
      total++; if (ifa.pc_o !== 32'h40) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=40", i, ifa.pc_o); end
    end
    drive(0, 0, 0, 0, 32'h0);
    total++; if (ifa.pc_o !== 32'h44) begin bad++; $display("FAIL post_stall_pc got=%h exp=44", ifa.pc_o); end
    drive(0, 1, 0, 0, 32'h200);
    total++; if (ifa.pc_o !== 32'h200) begin bad++; $display("FAIL branch_pc got=%h exp=200", ifa.pc_o); end
  endtask

  task automatic test_call_ret();
    do_reset();
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h10);
    drive(0, 0, 1, 0, 32'h300);
    total++; if (ifa.pc_o !== 32'h300) begin bad++; $display("FAIL call_pc got=%h exp=300", ifa.pc_o); end
    total++; if (ifa.ras_empty_o !== 1'b0) begin bad++; $display("FAIL call_empty got=%b exp=0", ifa.ras_empty_o); end
    drive(0, 0, 0, 1, 32'h0);
    total++; if (ifa.pc_o !== 32'h14) begin bad++; $display("FAIL ret_pc got=%h exp=14", ifa.pc_o); end
    total++; if (ifa.ras_empty_o !== 1'b1) begin bad++; $display("FAIL ret_empty got=%b exp=1", ifa.ras_empty_o); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] rets [4];
    rets[0] = 32'h404; rets[1] = 32'h304; rets[2] = 32'h204; rets[3] = 32'h104;
    do_reset();
    drive(0, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 4; i++) drive(0, 0, 1, 0, 32'h100 * i);
    total++; if (ifa.ras_full_o !== 1'b1 || ifa.ras_overflow_o !== 1'b0) begin bad++; $display("FAIL full4 got full=%b ovf=%b exp full=1 ovf=0", ifa.ras_full_o, ifa.ras_overflow_o); end
    drive(0, 0, 1, 0, 32'h500);
    total++; if (ifa.ras_full_o !== 1'b1) begin bad++; $display("FAIL full5 got=%b exp=1", ifa.ras_full_o); end
    total++; if (ifa.ras_overflow_o !== 1'b1) begin bad++; $display("FAIL ovf5 got=%b exp=1", ifa.ras_overflow_o); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 32'h0);
      total++; if (ifa.pc_o !== rets[i]) begin bad++; $display("FAIL ovf_ret[%0d] got=%h exp=%h", i, ifa.pc_o, rets[i]); end
    end
    drive(0, 0, 0, 1, 32'h0);
    total++; if (ifa.pc_o !== 32'h100 || ifa.trap_o !== 1'b1) begin bad++; $display("FAIL underflow got pc=%h trap=%b exp pc=100 trap=1", ifa.pc_o, ifa.trap_o); end
    drive(0, 0, 0, 0, 32'h0);
    total++; if (ifa.trap_o !== 1'b0 || ifa.pc_o !== 32'h104) begin bad++; $display("FAIL trap_pulse got pc=%h trap=%b exp pc=104 trap=0", ifa.pc_o, ifa.trap_o); end
    total++; if (ifa.ras_overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ifa.ras_overflow_o); end
  endtask

  task automatic test_misalign();
    do_reset();
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h202);
    total++; if (ifa.pc_o !== 32'h100 || ifa.trap_o !== 1'b1) begin bad++; $display("FAIL mis_branch got pc=%h trap=%b exp pc=100 trap=1", ifa.pc_o, ifa.trap_o); end
    drive(0, 1, 0, 0, 32'h20);
    total++; if (ifa.pc_o !== 32'h20 || ifa.trap_o !== 1'b0) begin bad++; $display("FAIL realign got pc=%h trap=%b exp pc=20 trap=0", ifa.pc_o, ifa.trap_o); end
    drive(0, 0, 1, 0, 32'h302);
    total++; if (ifa.pc_o !== 32'h100 || ifa.trap_o !== 1'b1) begin bad++; $display("FAIL mis_call got pc=%h trap=%b exp pc=100 trap=1", ifa.pc_o, ifa.trap_o); end
    total++; if (ifa.ras_empty_o !== 1'b0) begin bad++; $display("FAIL mis_call_push got empty=%b exp=0", ifa.ras_empty_o); end
    drive(0, 0, 0, 1, 32'h0);
    total++; if (ifa.pc_o !== 32'h24) begin bad++; $display("FAIL mis_call_ret got=%h exp=24", ifa.pc_o); end
  endtask

  task automatic test_random();
    bit st, br, ca, re;
    logic [31:0] tg;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 9) == 0);
      br = $urandom_range(0, 1);
      ca = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 2) == 0);
      tg = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 11) == 0) tg[1:0] = 2'($urandom_range(1, 3));
      drive(st, br, ca, re, tg);
      total++; if (ifa.pc_o !== pc_m) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, ifa.pc_o, pc_m); end
      total++; if (ifa.trap_o !== trap_m) begin bad++; $display("FAIL rnd_trap[%0d] got=%b exp=%b", i, ifa.trap_o, trap_m); end
      total++; if (ifa.ras_empty_o !== (ras_m.size() == 0)) begin bad++; $display("FAIL rnd_empty[%0d] got=%b exp=%0d", i, ifa.ras_empty_o, ras_m.size() == 0); end
      total++; if (ifa.ras_full_o !== (ras_m.size() == 4)) begin bad++; $display("FAIL rnd_full[%0d] got=%b exp=%0d", i, ifa.ras_full_o, ras_m.size() == 4); end
      total++; if (ifa.ras_overflow_o !== ovf_m) begin bad++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, ifa.ras_overflow_o, ovf_m); end
    end
  endtask

  task automatic test_wrap8();
    do_reset();
    driveb(0, 0, 0, 8'h0);
    driveb(1, 0, 0, 8'hFC);
    total++; if (ifb.pc_o !== 8'hFC) begin bad++; $display("FAIL w8_fc got=%h exp=fc", ifb.pc_o); end
    driveb(0, 0, 0, 8'h0);
    total++; if (ifb.pc_o !== 8'h00) begin bad++; $display("FAIL w8_wrap got=%h exp=00", ifb.pc_o); end
    driveb(1, 0, 0, 8'h4C);
    driveb(0, 1, 0, 8'h10);
    total++; if (ifb.pc_o !== 8'h10) begin bad++; $display("FAIL w8_call got=%h exp=10", ifb.pc_o); end
    driveb(0, 1, 1, 8'h80);
    total++; if (ifb.pc_o !== 8'h80 || ifb.trap_o !== 1'b0) begin bad++; $display("FAIL w8_swap got pc=%h trap=%b exp pc=80 trap=0", ifb.pc_o, ifb.trap_o); end
    total++; if (ifb.ras_empty_o !== 1'b0 || ifb.ras_full_o !== 1'b0) begin bad++; $display("FAIL w8_swap_cnt got empty=%b full=%b exp 0 0", ifb.ras_empty_o, ifb.ras_full_o); end
    driveb(0, 0, 1, 8'h0);
    total++; if (ifb.pc_o !== 8'h14) begin bad++; $display("FAIL w8_top got=%h exp=14", ifb.pc_o); end
    total++; if (ifb.ras_empty_o !== 1'b1) begin bad++; $display("FAIL w8_empty got=%b exp=1", ifb.ras_empty_o); end
  endtask

  initial begin
    ifa.stall_i = 0; ifa.branch_i = 0; ifa.call_i = 0; ifa.ret_i = 0; ifa.branch_target_i = '0;
    ifb.stall_i = 0; ifb.branch_i = 0; ifb.call_i = 0; ifb.ret_i = 0; ifb.branch_target_i = '0;
    test_reset();
    test_stall_branch();
    test_call_ret();
    test_ras_overflow();
    test_misalign();
    test_random();
    ifa.stall_i = 0; ifa.branch_i = 0; ifa.call_i = 0; ifa.ret_i = 0;
    test_wrap8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
